// File: rtl/bp_pkg.sv
// Shared helpers for the set-associative branch predictor: geometry derivations
// and saturating-counter arithmetic.
package bp_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int set_bits(input int lines, input int ways);
    return clog2(lines / ways);
  endfunction

  function automatic int tag_bits(input int pc_width, input int pc_lsb, input int lines,
                                  input int ways);
    return pc_width - pc_lsb - set_bits(lines, ways);
  endfunction

  // Ages and way indices share this width; a direct-mapped table still gets one bit.
  function automatic int age_bits(input int ways);
    return (clog2(ways) < 1) ? 1 : clog2(ways);
  endfunction

  function automatic int sat_inc(input int c, input int width);
    return (c >= (1 << width) - 1) ? c : c + 1;
  endfunction

  function automatic int sat_dec(input int c);
    return (c <= 0) ? c : c - 1;
  endfunction

  function automatic int cntr_init(input bit taken, input int width);
    return taken ? (1 << (width - 1)) : (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_lru_set.sv
// True-LRU bookkeeping for one set: picks the way to update (hit way or victim)
// and produces the set's next age vector.
module bp_lru_set
  import bp_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int AGE_BITS = 1
) (
  input  logic [WAYS-1:0]               valid,
  input  logic [WAYS-1:0][AGE_BITS-1:0] age_in,
  input  logic                          hit,
  input  logic [AGE_BITS-1:0]           hit_way,
  output logic [AGE_BITS-1:0]           way_sel,
  output logic [WAYS-1:0][AGE_BITS-1:0] age_out
);

  logic [AGE_BITS-1:0] victim;
  logic [AGE_BITS-1:0] old_age;

  always_comb begin
    victim = '0;
    // Descending scans so the lowest matching index is the one left standing.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (age_in[i] == AGE_BITS'(WAYS - 1)) victim = AGE_BITS'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) victim = AGE_BITS'(i);
    end
    way_sel = hit ? hit_way : victim;

    old_age = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_BITS'(i) == way_sel) old_age = age_in[i];
    end

    for (int i = 0; i < WAYS; i++) begin
      age_out[i] = age_in[i];
      if (AGE_BITS'(i) == way_sel) age_out[i] = '0;
      else if (age_in[i] < old_age) age_out[i] = age_in[i] + AGE_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_assoc.sv
// N-way set-associative branch history table with true-LRU replacement.
// Define BP_GSHARE_EN to XOR a global history register into the set index.
module branch_predictor_assoc
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int LINES      = 8,
  parameter int WAYS       = 2,
  parameter int CNTR_WIDTH = 2,
  parameter int PC_LSB     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                br_taken_check,
  output logic                br_pred_taken,
  output logic                br_pred_hit
);

  localparam int SETS     = LINES / WAYS;
  localparam int SET_BITS = set_bits(LINES, WAYS);
  localparam int IDX_W    = (SET_BITS == 0) ? 1 : SET_BITS;
  localparam int TAG_BITS = tag_bits(PC_WIDTH, PC_LSB, LINES, WAYS);
  localparam int AGE_BITS = age_bits(WAYS);

  logic [TAG_BITS-1:0]           tag_q   [SETS][WAYS];
  logic [CNTR_WIDTH-1:0]         cntr_q  [SETS][WAYS];
  logic [WAYS-1:0]               valid_q [SETS];
  logic [WAYS-1:0][AGE_BITS-1:0] age_q   [SETS];

  logic [IDX_W-1:0]    pc_idx_g, pc_idx_c, idx_g, idx_c;
  logic [TAG_BITS-1:0] tag_g, tag_c;

  assign tag_g = pc_guess[PC_WIDTH-1:PC_LSB+SET_BITS];
  assign tag_c = pc_check[PC_WIDTH-1:PC_LSB+SET_BITS];

  generate
    if (SET_BITS > 0) begin : g_idx
      assign pc_idx_g = pc_guess[PC_LSB+SET_BITS-1:PC_LSB];
      assign pc_idx_c = pc_check[PC_LSB+SET_BITS-1:PC_LSB];
    end else begin : g_no_idx
      assign pc_idx_g = '0;
      assign pc_idx_c = '0;
    end
  endgenerate

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // The check port indexes with the history as it was before this update.
  always_ff @(posedge clk) begin
    if (reset) ghr <= '0;
    else if (is_br_check) ghr <= IDX_W'({ghr, br_taken_check});
  end

  generate
    if (SET_BITS > 0) begin : g_gshare
      assign idx_g = pc_idx_g ^ ghr;
      assign idx_c = pc_idx_c ^ ghr;
    end else begin : g_gshare_single
      assign idx_g = '0;
      assign idx_c = '0;
    end
  endgenerate
`else
  assign idx_g = pc_idx_g;
  assign idx_c = pc_idx_c;
`endif

  logic hit_g, msb_g;

  always_comb begin
    hit_g = 1'b0;
    msb_g = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_g][w] && tag_q[idx_g][w] == tag_g) begin
        hit_g = 1'b1;
        msb_g = cntr_q[idx_g][w][CNTR_WIDTH-1];
      end
    end
  end

  assign br_pred_hit   = hit_g;
  assign br_pred_taken = is_br_guess & hit_g & msb_g;

  logic                          hit_c;
  logic [AGE_BITS-1:0]           hit_way_c, way_sel;
  logic [WAYS-1:0][AGE_BITS-1:0] age_nxt;
  logic [CNTR_WIDTH-1:0]         cntr_cur, cntr_nxt;

  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_c][w] && tag_q[idx_c][w] == tag_c) begin
        hit_c     = 1'b1;
        hit_way_c = AGE_BITS'(w);
      end
    end
  end

  bp_lru_set #(
    .WAYS     (WAYS),
    .AGE_BITS (AGE_BITS)
  ) u_lru (
    .valid   (valid_q[idx_c]),
    .age_in  (age_q[idx_c]),
    .hit     (hit_c),
    .hit_way (hit_way_c),
    .way_sel (way_sel),
    .age_out (age_nxt)
  );

  always_comb begin
    cntr_cur = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_BITS'(w) == way_sel) cntr_cur = cntr_q[idx_c][w];
    end
    if (!hit_c) cntr_nxt = CNTR_WIDTH'(cntr_init(br_taken_check, CNTR_WIDTH));
    else if (br_taken_check) cntr_nxt = CNTR_WIDTH'(sat_inc(int'(cntr_cur), CNTR_WIDTH));
    else cntr_nxt = CNTR_WIDTH'(sat_dec(int'(cntr_cur)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_BITS'(w);
      end
    end else if (is_br_check) begin
      age_q[idx_c] <= age_nxt;
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_BITS'(w) == way_sel) valid_q[idx_c][w] <= 1'b1;
      end
    end
  end

  // Tags and counters are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && is_br_check) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_BITS'(w) == way_sel) begin
          tag_q[idx_c][w]  <= tag_c;
          cntr_q[idx_c][w] <= cntr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_assoc.sv
// Bench for branch_predictor_assoc: recency-list reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_branch_predictor_assoc;

  localparam int NSETS = 4;
  localparam int NWAYS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_guess = '0, pc_check = '0;
  logic        is_br_guess = 1'b0, is_br_check = 1'b0, br_taken_check = 1'b0;
  logic        pred_taken, pred_hit, pred_taken3, pred_hit3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  branch_predictor_assoc dut (
    .clk(clk), .reset(reset), .pc_guess(pc_guess), .is_br_guess(is_br_guess),
    .pc_check(pc_check), .is_br_check(is_br_check), .br_taken_check(br_taken_check),
    .br_pred_taken(pred_taken), .br_pred_hit(pred_hit)
  );

  branch_predictor_assoc #(.CNTR_WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .pc_guess(pc_guess), .is_br_guess(is_br_guess),
    .pc_check(pc_check), .is_br_check(is_br_check), .br_taken_check(br_taken_check),
    .br_pred_taken(pred_taken3), .br_pred_hit(pred_hit3)
  );

  // Reference model: per-set recency list, most recently used way at the front.
  bit          m_valid [NSETS][NWAYS];
  int unsigned m_tag   [NSETS][NWAYS];
  int          m_cntr  [NSETS][NWAYS];
  int          order   [NSETS][$];

  task automatic m_reset();
    for (int s = 0; s < NSETS; s++) begin
      order[s].delete();
      for (int w = 0; w < NWAYS; w++) begin
        m_valid[s][w] = 1'b0;
        order[s].push_back(w);
      end
    end
  endtask

  function automatic int m_find(input logic [31:0] pc);
    int unsigned s = pc % NSETS;
    int unsigned tg = pc / NSETS;
    int way = -1;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) way = w;
    return way;
  endfunction

  task automatic m_update(input logic [31:0] pc, input bit t);
    int unsigned s = pc % NSETS;
    int unsigned tg = pc / NSETS;
    int w = m_find(pc);
    int pos = 0;
    if (w >= 0) begin
      if (t) m_cntr[s][w] = (m_cntr[s][w] >= 3) ? 3 : m_cntr[s][w] + 1;
      else   m_cntr[s][w] = (m_cntr[s][w] <= 0) ? 0 : m_cntr[s][w] - 1;
    end else begin
      w = order[s][$];
      for (int i = NWAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = tg;
      m_cntr[s][w]  = t ? 2 : 1;
    end
    for (int i = 0; i < order[s].size(); i++) if (order[s][i] == w) pos = i;
    order[s].delete(pos);
    order[s].push_front(w);
  endtask

  always @(posedge clk) begin
    if (reset) m_reset();
    else if (is_br_check) m_update(pc_check, br_taken_check);
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int w;
      bit exp_hit, exp_tk;
      w = m_find(pc_guess);
      exp_hit = (w >= 0);
      exp_tk  = is_br_guess && exp_hit && (m_cntr[pc_guess % NSETS][w] >= 2);
      chk("model_hit", pred_hit, exp_hit);
      chk("model_taken", pred_taken, exp_tk);
    end
  end

  task automatic step(input logic [31:0] g, input logic gb, input logic [31:0] c,
                      input logic cb, input logic ct, input logic r = 1'b0);
    @(posedge clk);
    #1;
    pc_guess = g; is_br_guess = gb; pc_check = c;
    is_br_check = cb; br_taken_check = ct; reset = r;
    @(negedge clk);
  endtask

  task automatic obs(input logic [31:0] g);
    step(g, 1'b1, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bit nt_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit ops3   [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit exp3   [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state, then weak-taken allocation and saturation at both ends.
    obs(32'h10);
    chk("rst_hit", pred_hit, 1'b0);
    chk("rst_taken", pred_taken, 1'b0);
    step(32'h10, 1'b1, 32'h10, 1'b1, 1'b1);
    chk("pre_update_hit", pred_hit, 1'b0);
    obs(32'h10);
    chk("alloc_hit", pred_hit, 1'b1);
    chk("alloc_taken", pred_taken, 1'b1);
    step(0, 0, 32'h10, 1'b1, 1'b1);
    step(0, 0, 32'h10, 1'b1, 1'b1);
    obs(32'h10);
    chk("sat_hi_taken", pred_taken, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h10, 1'b1, 1'b0);
      obs(32'h10);
      chk($sformatf("nt_seq%0d", i), pred_taken, nt_exp[i]);
    end

    // 3-bit counter instance on PC 0x5.
    step(0, 0, 32'h5, 1'b1, 1'b1);
    obs(32'h5);
    chk("cw3_hit", pred_hit3, 1'b1);
    chk("cw3_init", pred_taken3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 32'h5, 1'b1, ops3[i]);
      obs(32'h5);
      chk($sformatf("cw3_seq%0d", i), pred_taken3, exp3[i]);
    end

    // Reset with a concurrent update: everything misses afterwards.
    step(32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1);
    obs(32'h10);
    chk("post_rst_hit10", pred_hit, 1'b0);
    obs(32'h5);
    chk("post_rst_hit5", pred_hit, 1'b0);
    chk("post_rst_hit5_cw3", pred_hit3, 1'b0);

    // LRU eviction in set 0.
    step(0, 0, 32'h0, 1'b1, 1'b1);
    step(0, 0, 32'h4, 1'b1, 1'b1);
    obs(32'h0);
    chk("assoc_hit0", pred_hit, 1'b1);
    obs(32'h4);
    chk("assoc_hit4", pred_hit, 1'b1);
    step(0, 0, 32'h0, 1'b1, 1'b1);
    step(0, 0, 32'h8, 1'b1, 1'b1);
    obs(32'h4);
    chk("evict_hit4", pred_hit, 1'b0);
    obs(32'h0);
    chk("keep_hit0", pred_hit, 1'b1);
    obs(32'h8);
    chk("new_hit8", pred_hit, 1'b1);

    // Check port idle: no change; is_br_guess gates only the taken output.
    for (int i = 0; i < 3; i++) step(32'h8, 1'b1, 32'h8, 1'b0, 1'b0);
    obs(32'h8);
    chk("idle_taken", pred_taken, 1'b1);
    step(32'h8, 1'b0, '0, 1'b0, 1'b0);
    chk("nobr_taken", pred_taken, 1'b0);
    chk("nobr_hit", pred_hit, 1'b1);

    // Same-entry guess and check in one cycle.
    step(0, 0, 32'h3, 1'b1, 1'b0);
    step(32'h3, 1'b1, 32'h3, 1'b1, 1'b1);
    chk("same_cyc_taken", pred_taken, 1'b0);
    obs(32'h3);
    chk("next_cyc_taken", pred_taken, 1'b1);

    // Random traffic over a small PC pool to force aliasing and eviction.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] g, c;
      g = 32'($urandom_range(0, 23));
      c = 32'($urandom_range(0, 23));
      if ($urandom_range(0, 7) == 0) c = c | 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) g = g | 32'h8000_0000;
      step(g, 1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
    end

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
